// File: rtl/bss_frame_encoder.sv
// BSS direct-inject frame encoder: latches 13 field bytes on start and streams
// STX, escaped body, escaped XOR checksum and ETX over a valid/ready byte interface.
module bss_frame_encoder #(
  parameter logic [7:0] STX_BYTE   = 8'h02,
  parameter logic [7:0] ETX_BYTE   = 8'h03,
  parameter logic [7:0] ESC_BYTE   = 8'h1B,
  parameter logic [7:0] ESC_OFFSET = 8'h80
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] command,
  input  logic [7:0] address_0,
  input  logic [7:0] address_1,
  input  logic [7:0] address_2,
  input  logic [7:0] address_3,
  input  logic [7:0] address_4,
  input  logic [7:0] address_5,
  input  logic [7:0] sv_0,
  input  logic [7:0] sv_1,
  input  logic [7:0] data_0,
  input  logic [7:0] data_1,
  input  logic [7:0] data_2,
  input  logic [7:0] data_3,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE,
    SEND_STX,
    BODY,
    ESC2,
    SEND_ETX,
    DONE
  } state_t;

  state_t     state_q;
  logic [3:0] idx_q;
  logic [7:0] fields_q [13];
  logic [7:0] chk_q;
  logic [7:0] tx_data_q;
  logic       tx_valid_q;
  logic       busy_q;
  logic       done_q;

  logic [7:0] inFields [13];
  logic [7:0] inChk_d;
  logic [3:0] nextPos_d;
  logic [7:0] curByte_d;
  logic [7:0] nextByte_d;
  state_t     advState_d;
  logic [3:0] advIdx_d;
  logic [7:0] advData_d;
  logic       xfer;

  function automatic logic isSpecial(input logic [7:0] b);
    return (b == 8'h02) || (b == 8'h03) || (b == 8'h06) ||
           (b == 8'h15) || (b == 8'h1B);
  endfunction

  assign xfer = tx_valid_q && tx_ready;

  // Position 13 is the checksum; position 14 means the body is exhausted and ETX follows.
  always_comb begin
    inFields[0]  = command;
    inFields[1]  = address_0;
    inFields[2]  = address_1;
    inFields[3]  = address_2;
    inFields[4]  = address_3;
    inFields[5]  = address_4;
    inFields[6]  = address_5;
    inFields[7]  = sv_0;
    inFields[8]  = sv_1;
    inFields[9]  = data_0;
    inFields[10] = data_1;
    inFields[11] = data_2;
    inFields[12] = data_3;
    inChk_d = 8'h00;
    for (int i = 0; i < 13; i++) begin
      inChk_d = inChk_d ^ inFields[i];
    end
    nextPos_d  = (state_q == SEND_STX) ? 4'd0 : idx_q + 4'd1;
    curByte_d  = (idx_q < 4'd13) ? fields_q[idx_q] : chk_q;
    nextByte_d = (nextPos_d < 4'd13) ? fields_q[nextPos_d] : chk_q;
    if (nextPos_d == 4'd14) begin
      advState_d = SEND_ETX;
      advIdx_d   = idx_q;
      advData_d  = ETX_BYTE;
    end else begin
      advState_d = BODY;
      advIdx_d   = nextPos_d;
      advData_d  = isSpecial(nextByte_d) ? ESC_BYTE : nextByte_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      idx_q      <= 4'd0;
      chk_q      <= 8'h00;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < 13; i++) begin
        fields_q[i] <= 8'h00;
      end
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            for (int i = 0; i < 13; i++) begin
              fields_q[i] <= inFields[i];
            end
            chk_q      <= inChk_d;
            idx_q      <= 4'd0;
            tx_data_q  <= STX_BYTE;
            tx_valid_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= SEND_STX;
          end
        end
        SEND_STX, ESC2: begin
          if (xfer) begin
            tx_data_q <= advData_d;
            idx_q     <= advIdx_d;
            state_q   <= advState_d;
          end
        end
        // In BODY the output holds either the raw byte or the ESC prefix for it.
        BODY: begin
          if (xfer) begin
            if (isSpecial(curByte_d)) begin
              tx_data_q <= curByte_d + ESC_OFFSET;
              state_q   <= ESC2;
            end else begin
              tx_data_q <= advData_d;
              idx_q     <= advIdx_d;
              state_q   <= advState_d;
            end
          end
        end
        SEND_ETX: begin
          if (xfer) begin
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
